// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with programmable almost-full/almost-empty flags, hysteretic
// upstream pause, sticky overflow/underflow reporting and a registered read port.
module fifo_flow_ctrl #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   af_thresh,
  input  logic [ADDR_SIZE:0]   ae_thresh,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [ADDR_SIZE:0]   data_count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 pause,
  output logic [1:0]           error
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE+1)'(DEPTH);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 aempty_q, aempty_d;
  logic                 afull_q, afull_d;
  logic                 pause_q, pause_d;
  logic [1:0]           error_q, error_d;
  logic                 push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so push on full still succeeds.
    push_ok = push && ((count_q != DEPTH_CNT) || pop_ok);

    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{ADDR_SIZE{1'b0}}, push_ok} - {{ADDR_SIZE{1'b0}}, pop_ok};
    data_out_d = pop_ok ? mem_q[rd_ptr_q] : data_out_q;
    valid_d    = pop_ok;

    // A fresh error in the clearing cycle keeps its bit set.
    error_d[0] = (push && !push_ok) || (error_q[0] && !err_clr);
    error_d[1] = (pop && !pop_ok)   || (error_q[1] && !err_clr);

    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    afull_d  = (count_d >= af_thresh);
    aempty_d = (count_d <= ae_thresh) && (count_d != '0);

    // Set has priority so a misprogrammed af <= ae still asserts pause.
    pause_d = pause_q;
    if (count_d >= af_thresh)
      pause_d = 1'b1;
    else if (count_d <= ae_thresh)
      pause_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b0;
      afull_q    <= 1'b0;
      pause_q    <= 1'b0;
      error_q    <= 2'b00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      aempty_q   <= aempty_d;
      afull_q    <= afull_d;
      pause_q    <= pause_d;
      error_q    <= error_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign data_count   = count_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign pause        = pause_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed bench for fifo_flow_ctrl (DEPTH = 4) with hand-computed expectations.
module tb_fifo_flow_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, err_clr;
  logic [5:0] data_in;
  logic [2:0] af_thresh, ae_thresh;
  logic [5:0] data_out;
  logic       valid_out;
  logic [2:0] data_count;
  logic       empty, full, almost_empty, almost_full, pause;
  logic [1:0] error;

  int checks = 0;
  int errors = 0;

  fifo_flow_ctrl #(.DATA_SIZE(6), .ADDR_SIZE(2)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .err_clr(err_clr),
    .data_out(data_out), .valid_out(valid_out), .data_count(data_count),
    .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .pause(pause), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ps, input logic pp, input logic [5:0] din, input logic clr);
    push = ps; pop = pp; data_in = din; err_clr = clr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, data_count, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_aempty"}, almost_empty, 0);
    check({tag, "_afull"}, almost_full, 0);
    check({tag, "_pause"}, pause, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_valid"}, valid_out, 0);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    af_thresh = 3'd4; ae_thresh = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // Fill, then drain in order
    for (int i = 1; i <= 4; i++) cyc(1, 0, 6'(i), 0);
    check("fill_count", data_count, 4);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    check("fill_afull", almost_full, 1);
    check("fill_pause", pause, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 0);
      check("drain_data", data_out, i);
      check("drain_valid", valid_out, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_count", data_count, 0);
    check("drain_pause", pause, 0);
    cyc(0, 0, 0, 0);
    check("idle_valid", valid_out, 0);

    // Overflow and push+pop on full
    for (int i = 1; i <= 4; i++) cyc(1, 0, 6'(i), 0);
    cyc(1, 0, 6'd5, 0);
    check("ovf_error", error, 2'b01);
    check("ovf_count", data_count, 4);
    cyc(0, 1, 0, 0);
    check("ovf_pop1", data_out, 1);
    cyc(1, 0, 6'd7, 0);
    check("refill_count", data_count, 4);
    cyc(1, 1, 6'd8, 0);
    check("pp_full_count", data_count, 4);
    check("pp_full_data", data_out, 2);
    check("pp_full_error", error, 2'b01);
    check("pp_full_full", full, 1);
    cyc(0, 1, 0, 0); check("ovf_pop3", data_out, 3);
    cyc(0, 1, 0, 0); check("ovf_pop4", data_out, 4);
    cyc(0, 1, 0, 0); check("ovf_pop7", data_out, 7);
    cyc(0, 1, 0, 0); check("ovf_pop8", data_out, 8);
    cyc(0, 0, 0, 1);
    check("clr_error", error, 2'b00);

    // Underflow
    cyc(0, 1, 0, 0);
    check("udf_error", error, 2'b10);
    check("udf_valid", valid_out, 0);
    check("udf_hold", data_out, 8);
    cyc(1, 1, 6'd9, 0);
    check("pp_empty_count", data_count, 1);
    check("pp_empty_error", error, 2'b10);
    check("pp_empty_valid", valid_out, 0);
    cyc(0, 0, 0, 1);
    check("clr2_error", error, 2'b00);
    cyc(0, 1, 0, 0);
    check("pop9", data_out, 9);
    cyc(0, 1, 0, 1);
    check("clr_vs_new", error, 2'b10);
    cyc(0, 0, 0, 1);
    check("clr3_error", error, 2'b00);

    // Hysteresis with af=3, ae=1
    af_thresh = 3'd3; ae_thresh = 3'd1;
    cyc(1, 0, 6'd10, 0);
    check("h1_aempty", almost_empty, 1);
    check("h1_pause", pause, 0);
    cyc(1, 0, 6'd11, 0);
    check("h2_pause", pause, 0);
    check("h2_aempty", almost_empty, 0);
    cyc(1, 0, 6'd12, 0);
    check("h3_pause", pause, 1);
    check("h3_afull", almost_full, 1);
    cyc(0, 1, 0, 0);
    check("h4_pause", pause, 1);
    check("h4_count", data_count, 2);
    check("h4_data", data_out, 10);
    cyc(0, 1, 0, 0);
    check("h5_pause", pause, 0);
    check("h5_aempty", almost_empty, 1);
    check("h5_data", data_out, 11);

    // Streaming across pointer wrap at fill level 1
    for (int k = 0; k < 12; k++) begin
      cyc(1, 1, 6'(20 + k), 0);
      check("stream_data", data_out, (k == 0) ? 12 : 20 + k - 1);
      check("stream_valid", valid_out, 1);
      check("stream_count", data_count, 1);
    end

    // Asynchronous reset mid-operation
    cyc(1, 0, 6'd32, 0);
    cyc(1, 0, 6'd33, 0);
    check("pre_rst_count", data_count, 3);
    check("pre_rst_pause", pause, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 1, 0, 0);
    check("post_rst_valid", valid_out, 0);
    check("post_rst_error", error, 2'b10);
    cyc(1, 0, 6'd40, 0);
    cyc(0, 1, 0, 0);
    check("post_rst_data", data_out, 40);
    check("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
